// File: rtl/disc_layer_driver.sv
// disc_layer_driver: initiator for one discriminator layer. It accepts an input
// vector, pulses layer_start, waits (with timeout) for layer_done, then streams
// the captured output vector one element per handshake and reports its signed
// argmax.
module disc_layer_driver #(
   parameter int IN_N    = 128,
   parameter int OUT_N   = 32,
   parameter int DW      = 16,
   parameter int TIMEOUT = 4096
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [DW*IN_N-1:0]       req_vec,
   output logic                     layer_start,
   output logic [DW*IN_N-1:0]       layer_input_flat,
   input  logic [DW*OUT_N-1:0]      layer_output_flat,
   input  logic                     layer_done,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DW-1:0]            out_data,
   output logic [$clog2(OUT_N)-1:0] out_index,
   output logic                     out_last,
   output logic                     argmax_valid,
   output logic [$clog2(OUT_N)-1:0] argmax_index,
   output logic                     timeout_err
);

   localparam int IW = $clog2(OUT_N);
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DRAIN} state_t;

   state_t                state, state_nxt;
   logic [CW-1:0]         cnt;
   logic [DW*OUT_N-1:0]   bank;
   logic [IW-1:0]         idx;
   logic signed [DW-1:0]  max_val;
   logic [IW-1:0]         max_idx;
   logic signed [DW-1:0]  elem;
   logic                  accept, done_ok, expired, hs, last_hs, take;

   // Current bank element and the handshake/argmax decisions derived from it.
   always_comb begin
      elem    = bank[int'(idx)*DW +: DW];
      accept  = (state == IDLE) && req_valid;
      // The first WAIT cycle (cnt == 0) is blanked so a level-high done left
      // over from the previous run cannot complete this one.
      done_ok = (state == WAIT) && (cnt != '0) && layer_done;
      expired = (state == WAIT) && (cnt == CW'(TIMEOUT));
      hs      = (state == DRAIN) && out_ready;
      last_hs = hs && (idx == IW'(OUT_N - 1));
      take    = (idx == '0) || (elem > max_val);
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state and state-decoded outputs.
   always_comb begin
      state_nxt   = state;
      req_ready   = 1'b0;
      layer_start = 1'b0;
      out_valid   = 1'b0;
      out_last    = 1'b0;
      out_data    = elem;
      out_index   = idx;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nxt = LAUNCH;
         end
         LAUNCH: begin
            layer_start = 1'b1;
            state_nxt   = WAIT;
         end
         WAIT: begin
            if (done_ok)      state_nxt = DRAIN;
            else if (expired) state_nxt = IDLE;
         end
         DRAIN: begin
            out_valid = 1'b1;
            out_last  = (idx == IW'(OUT_N - 1));
            if (last_hs) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Input latch, wait counter, output bank, stream index and error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         layer_input_flat <= '0;
         timeout_err      <= 1'b0;
         cnt              <= '0;
         bank             <= '0;
         idx              <= '0;
      end else begin
         if (accept) begin
            layer_input_flat <= req_vec;
            timeout_err      <= 1'b0;
         end
         if (state == LAUNCH)    cnt <= '0;
         else if (state == WAIT) cnt <= cnt + 1'b1;
         if (done_ok) begin
            bank <= layer_output_flat;
            idx  <= '0;
         end else if (expired) begin
            timeout_err <= 1'b1;
         end
         if (last_hs)  idx <= '0;
         else if (hs)  idx <= idx + 1'b1;
      end
   end

   // Running signed max; strict compare keeps the lowest index on ties.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         max_val      <= '0;
         max_idx      <= '0;
         argmax_index <= '0;
         argmax_valid <= 1'b0;
      end else begin
         argmax_valid <= last_hs;
         if (hs && take) begin
            max_val <= elem;
            max_idx <= idx;
         end
         if (last_hs) argmax_index <= take ? idx : max_idx;
      end
   end

endmodule

// File: tb/tb_disc_layer_driver.sv
// Testbench for disc_layer_driver: table of scenarios plus randomized runs,
// checked against a reference built from plain arrays.
module tb_disc_layer_driver;

   localparam int IN_N  = 128;
   localparam int OUT_N = 32;
   localparam int DW    = 16;
   localparam int TO    = 16;
   localparam int IW    = $clog2(OUT_N);

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 req_valid = 1'b0;
   logic                 req_ready;
   logic [DW*IN_N-1:0]   req_vec = '0;
   logic                 layer_start;
   logic [DW*IN_N-1:0]   layer_input_flat;
   logic [DW*OUT_N-1:0]  layer_output_flat = '0;
   logic                 layer_done = 1'b0;
   logic                 out_valid;
   logic                 out_ready = 1'b0;
   logic [DW-1:0]        out_data;
   logic [IW-1:0]        out_index;
   logic                 out_last;
   logic                 argmax_valid;
   logic [IW-1:0]        argmax_index;
   logic                 timeout_err;

   disc_layer_driver #(.IN_N(IN_N), .OUT_N(OUT_N), .DW(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_vec(req_vec),
      .layer_start(layer_start), .layer_input_flat(layer_input_flat),
      .layer_output_flat(layer_output_flat), .layer_done(layer_done),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_index(out_index), .out_last(out_last),
      .argmax_valid(argmax_valid), .argmax_index(argmax_index),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // pat: 0 bias 0x0100*k, 1 ties, 2 small random, 3 full random, 4 all equal
   // rmode: 0 always ready, 1 pattern 1,0,0,1, 2 random
   typedef struct {
      int pat; int stale; int done_at; int rmode; int hold; int zero; int exp_am; int abort;
   } rec_t;

   rec_t               tbl[10];
   int                 tests = 0;
   int                 fails = 0;
   logic [DW-1:0]      eo [OUT_N];
   logic [DW*IN_N-1:0] vec;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [DW*OUT_N-1:0] rand_out();
      logic [DW*OUT_N-1:0] f;
      for (int i = 0; i < DW*OUT_N/32; i++) f[i*32 +: 32] = $urandom();
      return f;
   endfunction

   function automatic logic [DW*IN_N-1:0] rand_in();
      logic [DW*IN_N-1:0] f;
      for (int i = 0; i < DW*IN_N/32; i++) f[i*32 +: 32] = $urandom();
      return f;
   endfunction

   task automatic fill(input int pat);
      int v;
      for (int k = 0; k < OUT_N; k++) begin
         case (pat)
            0: eo[k] = 16'(k * 256);
            1: eo[k] = (k == 7 || k == 19) ? 16'h0080 : 16'h8000;
            2: begin v = $urandom_range(0, 8); eo[k] = 16'((v - 4) * 256); end
            3: eo[k] = 16'($urandom());
            default: eo[k] = 16'h1234;
         endcase
      end
   endtask

   function automatic int model_argmax();
      int best = 0;
      for (int k = 1; k < OUT_N; k++)
         if ($signed(eo[k]) > $signed(eo[best])) best = k;
      return best;
   endfunction

   task automatic run_one(input rec_t r);
      int cap, last, k, cyc, exp_am;
      bit rdy;
      logic [DW*OUT_N-1:0] good;
      fill(r.pat);
      for (int i = 0; i < OUT_N; i++) good[i*DW +: DW] = eo[i];
      exp_am = (r.exp_am >= 0) ? r.exp_am : model_argmax();
      vec = r.zero ? '0 : rand_in();
      // first cycle at which the driver may legally take done
      cap = -1;
      for (int n = 2; n <= TO + 1; n++)
         if ((n < r.stale) || (n >= r.done_at)) begin cap = n; break; end
      last = (cap >= 0) ? cap : TO + 1;

      chk("idle_ready", req_ready, 1);
      req_vec = vec;
      req_valid = 1'b1;
      @(negedge clk);
      chk("launch_start", layer_start, 1);
      chk("launch_not_ready", req_ready, 0);
      chk("launch_err_clear", timeout_err, 0);
      chk("launch_in_flat", 64'(layer_input_flat == vec), 1);
      req_valid = 1'(r.hold);
      req_vec = ~vec;
      for (int n = 0; n <= last; n++) begin
         if (n > 0) begin
            @(negedge clk);
            chk("wait_no_valid", out_valid, 0);
            chk("wait_no_start", layer_start, 0);
            if (n == TO + 1) chk("wait_err_early", timeout_err, 0);
         end
         layer_done = (n < r.stale) || (n >= r.done_at);
         layer_output_flat = (n == cap) ? good : rand_out();
      end
      @(negedge clk);
      if (cap < 0) begin
         chk("to_err", timeout_err, 1);
         chk("to_ready", req_ready, 1);
         chk("to_no_valid", out_valid, 0);
         layer_done = 1'b0;
         req_valid = 1'b0;
         @(negedge clk);
         chk("to_err_sticky", timeout_err, 1);
         chk("to_no_valid2", out_valid, 0);
         return;
      end

      k = 0;
      cyc = 0;
      while (k < OUT_N && cyc < 400) begin
         chk("drain_valid", out_valid, 1);
         chk("drain_data", out_data, eo[k]);
         chk("drain_index", out_index, k);
         chk("drain_last", out_last, (k == OUT_N - 1));
         chk("drain_no_am", argmax_valid, 0);
         if (k == r.abort) begin
            rst_n = 1'b0;
            #1;
            chk("rst_ready", req_ready, 1);
            chk("rst_start", layer_start, 0);
            chk("rst_valid", out_valid, 0);
            chk("rst_last", out_last, 0);
            chk("rst_am_valid", argmax_valid, 0);
            chk("rst_err", timeout_err, 0);
            chk("rst_data", out_data, 0);
            chk("rst_index", out_index, 0);
            chk("rst_am_index", argmax_index, 0);
            chk("rst_in_flat", 64'(layer_input_flat == '0), 1);
            req_valid = 1'b0;
            layer_done = 1'b0;
            out_ready = 1'b0;
            @(negedge clk);
            chk("rst_hold_start", layer_start, 0);
            rst_n = 1'b1;
            return;
         end
         case (r.rmode)
            0: rdy = 1'b1;
            1: rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         out_ready = rdy;
         layer_output_flat = rand_out();
         @(posedge clk);
         if (rdy) k++;
         cyc++;
         @(negedge clk);
      end
      if (k < OUT_N) chk("drain_bound", k, OUT_N);
      out_ready = 1'b0;
      req_valid = 1'b0;
      chk("am_valid", argmax_valid, 1);
      chk("am_index", argmax_index, exp_am);
      chk("end_no_valid", out_valid, 0);
      chk("end_ready", req_ready, 1);
      chk("end_in_flat", 64'(layer_input_flat == vec), 1);
      if (r.rmode == 0) chk("drain_cycles", cyc, OUT_N);
      if (r.rmode == 1) chk("drain_cycles_bp", cyc, 2 * OUT_N);
      @(negedge clk);
      chk("am_pulse_end", argmax_valid, 0);
      chk("am_index_hold", argmax_index, exp_am);
   endtask

   initial begin
      rec_t r;
      tbl[0] = '{0, 0, 5,    0, 0, 1, 31, -1};  // zero input, bias outputs
      tbl[1] = '{3, 2, 5,    0, 0, 0, -1, -1};  // stale done through blanking
      tbl[2] = '{3, 0, 2,    1, 0, 0, -1, -1};  // backpressure 1,0,0,1
      tbl[3] = '{1, 0, 2,    2, 1, 0,  7, -1};  // signed ties, req_valid held
      tbl[4] = '{2, 0, 1000, 0, 0, 0, -1, -1};  // timeout
      tbl[5] = '{4, 1, 3,    0, 0, 0,  0, -1};  // clears error, all equal
      tbl[6] = '{2, 0, TO,   2, 0, 0, -1, -1};  // late done
      tbl[7] = '{0, 0, 2,    0, 0, 0, 31, -1};  // bias run
      tbl[8] = '{0, 0, 2,    0, 0, 0, 31, 10};  // reset at index 10
      tbl[9] = '{2, 0, 2,    0, 0, 0, -1, -1};  // fresh run after reset

      #1;
      chk("reset_ready", req_ready, 1);
      chk("reset_start", layer_start, 0);
      chk("reset_valid", out_valid, 0);
      chk("reset_last", out_last, 0);
      chk("reset_am_valid", argmax_valid, 0);
      chk("reset_err", timeout_err, 0);
      chk("reset_data", out_data, 0);
      chk("reset_index", out_index, 0);
      chk("reset_am_index", argmax_index, 0);
      chk("reset_in_flat", 64'(layer_input_flat == '0), 1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) run_one(tbl[i]);

      for (int i = 0; i < 6; i++) begin
         r.pat     = $urandom_range(2, 3);
         r.stale   = $urandom_range(0, 3);
         r.done_at = $urandom_range(2, 12);
         r.rmode   = 2;
         r.hold    = $urandom_range(0, 1);
         r.zero    = 0;
         r.exp_am  = -1;
         r.abort   = -1;
         run_one(r);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "time limit");
   end

endmodule
